// File: rtl/barrel_rotator_pipelined.sv
// barrel_rotator_pipelined
//
// Pipelined dynamic barrel rotator / logical shifter with a valid/ready
// stream interface. Each transaction carries its own amount, direction and
// mode. The log2(WIDTH) binary levels of the shift network are spread over
// STAGES register stages so that wide datapaths can close timing.
//
// Parameters:
//   WIDTH        data width, power of two, >= 2
//   STAGES       number of register stages, 1 .. AMOUNT_WIDTH
//   AMOUNT_WIDTH derived, log2(WIDTH)
//
// Ports:
//   clock         rising-edge clock
//   resetn        asynchronous active-low reset
//   in_data       data to rotate / shift
//   in_amount     rotation / shift amount, 0 .. WIDTH-1
//   in_direction  0 = left (toward MSB), 1 = right
//   in_mode       0 = rotate, 1 = logical shift (vacated bits zero)
//   in_valid      input transaction valid
//   in_ready      block can accept this cycle (combinational)
//   out_data      result (registered)
//   out_valid     result valid (registered)
//   out_ready     consumer accepts the result

module barrel_rotator_pipelined #(
   parameter  int WIDTH        = 8,
   parameter  int STAGES       = 1,
   localparam int AMOUNT_WIDTH = $clog2(WIDTH)
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic [WIDTH-1:0]        in_data,
   input  logic [AMOUNT_WIDTH-1:0] in_amount,
   input  logic                    in_direction,
   input  logic                    in_mode,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready
);

   // Mirror a word end for end. Right moves are done by mirroring the
   // operand, moving it left, and mirroring the result back.
   function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = d[WIDTH-1-i];
      end
      return r;
   endfunction

   // Apply the levels of the left network that belong to one stage. Level k
   // moves by 2^k and lives in stage floor(k*STAGES/AMOUNT_WIDTH). In shift
   // mode the bits leaving the top are dropped instead of wrapping around.
   function automatic logic [WIDTH-1:0] stage_network(
      input logic [WIDTH-1:0]        d,
      input logic [AMOUNT_WIDTH-1:0] amount,
      input logic                    mode,
      input int                      stage
   );
      logic [WIDTH-1:0] r;
      r = d;
      for (int k = 0; k < AMOUNT_WIDTH; k++) begin
         if ((((k * STAGES) / AMOUNT_WIDTH) == stage) && amount[k]) begin
            if (mode) begin
               r = r << (1 << k);
            end else begin
               r = (r << (1 << k)) | (r >> (WIDTH - (1 << k)));
            end
         end
      end
      return r;
   endfunction

   logic [STAGES-1:0] stage_valid;
   logic [STAGES-1:0] stage_load;

   // Handshake chain, evaluated from the output backwards. A stage may load
   // a new entry when it is empty or when its current entry moves on this
   // cycle; the last stage's entry moves when the consumer takes it. This
   // collapses bubbles and lets in_ready follow out_ready combinationally.
   always_comb begin
      logic downstream_takes;
      downstream_takes = out_ready;
      for (int s = STAGES - 1; s >= 0; s--) begin
         stage_load[s]    = !stage_valid[s] || downstream_takes;
         downstream_takes = stage_load[s];
      end
   end

   assign in_ready  = stage_load[0];
   assign out_valid = stage_valid[STAGES-1];

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic [WIDTH-1:0]        src_data;
      logic [WIDTH-1:0]        left_data;
      logic [WIDTH-1:0]        net_data;
      logic [AMOUNT_WIDTH-1:0] src_amount;
      logic                    src_direction;
      logic                    src_mode;
      logic                    src_valid;
      logic [WIDTH-1:0]        data_q;
      logic                    valid_q;

      if (s == 0) begin : g_src_input
         assign src_data      = in_direction ? bit_reverse(in_data) : in_data;
         assign src_amount    = in_amount;
         assign src_direction = in_direction;
         assign src_mode      = in_mode;
         assign src_valid     = in_valid;
      end else begin : g_src_prev
         assign src_data      = g_stage[s-1].data_q;
         assign src_amount    = g_stage[s-1].g_ctrl.amount_q;
         assign src_direction = g_stage[s-1].g_ctrl.direction_q;
         assign src_mode      = g_stage[s-1].g_ctrl.mode_q;
         assign src_valid     = g_stage[s-1].valid_q;
      end

      assign left_data = stage_network(src_data, src_amount, src_mode, s);

      // The final stage undoes the input mirror before registering, so
      // out_data comes straight from a flop and is already in natural order.
      if (s == STAGES - 1) begin : g_last
         assign net_data = src_direction ? bit_reverse(left_data) : left_data;
         assign out_data = data_q;
      end else begin : g_mid
         assign net_data = left_data;
      end

      assign stage_valid[s] = valid_q;

      // Stage payload and valid flag. An entry that cannot move keeps its
      // value, which is what holds out_data steady under backpressure.
      always_ff @(posedge clock or negedge resetn) begin
         if (!resetn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else if (stage_load[s]) begin
            data_q  <= net_data;
            valid_q <= src_valid;
         end
      end

      // Control fields travel with the partly moved data so later stages
      // know which of their levels to apply and whether to mirror back.
      // The last stage holds a finished result and needs none of them.
      if (s < STAGES - 1) begin : g_ctrl
         logic [AMOUNT_WIDTH-1:0] amount_q;
         logic                    direction_q;
         logic                    mode_q;

         always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
               amount_q    <= '0;
               direction_q <= 1'b0;
               mode_q      <= 1'b0;
            end else if (stage_load[s]) begin
               amount_q    <= src_amount;
               direction_q <= src_direction;
               mode_q      <= src_mode;
            end
         end
      end
   end

endmodule
